// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers (WIDTH steps plus one sign-fix cycle).
// Optional feature: define MDU_DIV0_EN for an early divide-by-zero exit and the div0 pulse port.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_EN
  ,
  output logic             div0
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div;
  logic             r_negq;
  logic             r_negr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_skip;

  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dtrial;
  logic               w_dq;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div0;

  // op[0]==0 selects the signed variants; operands are reduced to magnitudes at launch
  assign w_rs_neg = ~op[0] & rs_data[WIDTH-1];
  assign w_rt_neg = ~op[0] & rt_data[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? f_neg(rs_data) : rs_data;
  assign w_rt_mag = w_rt_neg ? f_neg(rt_data) : rt_data;

  assign w_msum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_dtrial = {r_acc, r_q[WIDTH-1]} - {1'b0, r_a};
  assign w_dq     = ~w_dtrial[WIDTH];

  assign w_prod = r_negq ? f_neg2({r_acc, r_q}) : {r_acc, r_q};
  assign w_quo  = r_negq ? f_neg(r_q) : r_q;
  assign w_rem  = r_negr ? f_neg(r_acc) : r_acc;

`ifdef MDU_DIV0_EN
  assign w_div0 = op[1] & (rt_data == '0);
`else
  assign w_div0 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_a     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= w_div0 ? S_FIX : S_RUN;
            r_skip  <= w_div0;
            r_cnt   <= '0;
            r_div   <= op[1];
            r_a     <= op[1] ? w_rt_mag : w_rs_mag;
            r_q     <= op[1] ? w_rs_mag : w_rt_mag;
            r_acc   <= '0;
            r_negq  <= w_rs_neg ^ w_rt_neg;
            r_negr  <= w_rs_neg;
          end else begin
            if (hi_wr) r_hi <= wd;
            if (lo_wr) r_lo <= wd;
          end
        end
        S_RUN: begin
          // divide: restoring shift-subtract; multiply: shift-add, product shifts right into r_q
          if (r_div) begin
            r_acc <= w_dq ? w_dtrial[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
            r_q   <= {r_q[WIDTH-2:0], w_dq};
          end else begin
            r_acc <= w_msum[WIDTH:1];
            r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_skip) begin
            if (r_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              {r_hi, r_lo} <= w_prod;
            end
          end
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MDU_DIV0_EN
  logic r_div0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_div0 <= 1'b0;
    else      r_div0 <= (r_state == S_FIX) & r_skip;
  end
  assign div0 = r_div0;
`endif

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: arithmetic reference model plus directed vectors.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MDU_DIV0_EN
  logic        div0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;
  int t0       = 0;
  int nb       = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MDU_DIV0_EN
    , .div0(div0)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns {HI, LO} for a completed operation, straight from the arithmetic definition.
  function automatic logic [63:0] f_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        qv = ua / ub;
        rv = ua % ub;
        return {rv[31:0], qv[31:0]};
      end
    endcase
  endfunction

  // Cycle-level expectation: busy for 33 edges after acceptance, result appears with done.
  logic        m_busy, m_done, m_div0, m_pdiv0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_rem;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_div0 <= 1'b0; m_pdiv0 <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_rem <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      m_div0 <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_div0 <= m_pdiv0;
          {m_hi, m_lo} <= m_pend;
        end
      end else if (start) begin
        m_busy <= 1'b1;
`ifdef MDU_DIV0_EN
        if (op[1] && rt_data == 32'd0) begin
          m_rem <= 1; m_pend <= {m_hi, m_lo}; m_pdiv0 <= 1'b1;
        end else begin
          m_rem <= 33; m_pend <= f_model(op, rs_data, rt_data); m_pdiv0 <= 1'b0;
        end
`else
        m_rem <= 33; m_pend <= f_model(op, rs_data, rt_data); m_pdiv0 <= 1'b0;
`endif
      end else begin
        if (hi_wr) m_hi <= wd;
        if (lo_wr) m_lo <= wd;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("busy", {63'd0, busy}, {63'd0, m_busy});
      check("done", {63'd0, done}, {63'd0, m_done});
      check("hi", {32'd0, hi}, {32'd0, m_hi});
      check("lo", {32'd0, lo}, {32'd0, m_lo});
`ifdef MDU_DIV0_EN
      check("div0", {63'd0, div0}, {63'd0, m_div0});
`endif
    end
  end

  // Called at a negedge; start is sampled by the following posedge (E0).
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    t0 = ecnt + 1;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    nb = busy ? 1 : 0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int k;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (busy) nb++;
    end
    if (!done) begin
      check({name, " done timeout"}, 64'd0, 64'd1);
    end else begin
      check({name, " latency"}, 64'(ecnt - t0), 64'(exp_lat));
      if (exp_busy >= 0) check({name, " busy cycles"}, 64'(nb), 64'(exp_busy));
    end
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo);
    launch(o, a, b);
    wait_done(name, 33, 33);
    check({name, " HI"}, {32'd0, hi}, {32'd0, ehi});
    check({name, " LO"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wd = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run("multu ff*ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult -3*5",   2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu 100/7",  2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
    run("div min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run("div 7/-2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run("mult min*min",2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run("mult 7*-1",   2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

    // start while busy, plus mthi while busy: both dropped
    launch(2'b01, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    start = 1'b1; hi_wr = 1'b1; wd = 32'h0000_1234; op = 2'b10;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0;
    wait_done("busy ignore", 33, -1);
    check("busy ignore HI", {32'd0, hi}, 64'd0);
    check("busy ignore LO", {32'd0, lo}, 64'h0000_000C);

    // start and mthi in the same idle cycle: start wins
    hi_wr = 1'b1; wd = 32'h0000_DEAD;
    launch(2'b01, 32'd2, 32'd3);
    wait_done("start wins", 33, 33);
    check("start wins HI", {32'd0, hi}, 64'd0);
    check("start wins LO", {32'd0, lo}, 64'h0000_0006);

    hi_wr = 1'b1; wd = 32'h0000_1234;
    @(negedge clk);
    hi_wr = 1'b0;
    check("mthi HI", {32'd0, hi}, 64'h0000_1234);
    check("mthi LO", {32'd0, lo}, 64'h0000_0006);
    lo_wr = 1'b1; wd = 32'h0000_5678;
    @(negedge clk);
    lo_wr = 1'b0;
    check("mtlo LO", {32'd0, lo}, 64'h0000_5678);

`ifdef MDU_DIV0_EN
    launch(2'b11, 32'd5, 32'd0);
    wait_done("divu 5/0", 1, 1);
    check("divu 5/0 div0", {63'd0, div0}, 64'd1);
    check("divu 5/0 HI", {32'd0, hi}, 64'h0000_1234);
    check("divu 5/0 LO", {32'd0, lo}, 64'h0000_5678);
`else
    run("divu 5/0", 2'b11, 32'd5,         32'd0, 32'h0000_0005, 32'hFFFF_FFFF);
    run("div -7/0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'h0000_0001);
`endif

    // asynchronous reset in the middle of a divide
    run("pre-reset", 2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
    launch(2'b10, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async rst busy", {63'd0, busy}, 64'd0);
    check("async rst done", {63'd0, done}, 64'd0);
    check("async rst hi", {32'd0, hi}, 64'd0);
    check("async rst lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run("after reset", 2'b10, 32'd1000, 32'd3, 32'h0000_0001, 32'h0000_014D);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
